seq_gen_kbonacci: RTL and testbench

Parametrised k-bonacci sequence generator. Each new term is the sum of the previous k terms, with k chosen at run time (2 = Fibonacci, 3 = Tribonacci, up to MAX_ORDER). Terms leave through a valid/ready stream with an index, a last-term marker and overflow handling. It is the generalised, flow-controlled successor to the fixed-width free-running Fibonacci generator.

---
 rtl/seq_gen_kbonacci_pkg.sv | 18 +
 rtl/seq_win_sum.sv | 37 +++
 rtl/seq_gen_kbonacci.sv | 141 ++++++++++++++
 tb/tb_seq_gen_kbonacci.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_kbonacci_pkg.sv
// seq_gen_pkg: shared types and helpers for the k-bonacci sequence generator.
//   state_t    : run-control FSM states
//   ORDER_MIN  : smallest legal order k
//   sum_width  : bit width needed to add MAX_ORDER terms of DATA_W bits
package seq_gen_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int ORDER_MIN = 2;

   function automatic int sum_width(input int data_w, input int max_order);
      return data_w + $clog2(max_order);
   endfunction

endpackage

// File: rtl/seq_win_sum.sv
// seq_win_sum: combinational masked adder over the first `order` window
// entries, with saturate/wrap selection of the stored result.
//   win    : window terms, entry 0 is the oldest
//   order  : number of entries to add (k)
//   sat_en : 1 = clamp to all-ones on overflow, 0 = keep low DATA_W bits
//   sum    : value to store as the next term
//   ovf    : the full-precision sum did not fit in DATA_W bits
module seq_win_sum
   import seq_gen_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int MAX_ORDER = 4,
   parameter int ORD_W     = $clog2(MAX_ORDER + 1)
) (
   input  logic [MAX_ORDER-1:0][DATA_W-1:0] win,
   input  logic [ORD_W-1:0]                 order,
   input  logic                             sat_en,
   output logic [DATA_W-1:0]                sum,
   output logic                             ovf
);

   localparam int SUM_W = sum_width(DATA_W, MAX_ORDER);

   logic [SUM_W-1:0] acc;

   always_comb begin
      acc = '0;
      for (int i = 0; i < MAX_ORDER; i++) begin
         if (ORD_W'(i) < order) acc = acc + SUM_W'(win[i]);
      end
   end

   // Any bit above DATA_W means the true sum exceeds 2^DATA_W-1.
   assign ovf = |acc[SUM_W-1:DATA_W];
   assign sum = (ovf && sat_en) ? '1 : acc[DATA_W-1:0];

endmodule

// File: rtl/seq_gen_kbonacci.sv
// seq_gen_kbonacci: run-time order k-bonacci generator with a valid/ready
// output stream.
//   clk, reset_n         : clock, asynchronous active-low reset
//   start_i              : begin a run (sampled only in IDLE)
//   order_i, n_terms_i   : order k, term count (0 = free-running)
//   sat_en_i             : saturate (1) or wrap (0) on overflow
//   seq_o, idx_o         : current term and its index
//   valid_o, ready_i     : output handshake
//   last_o               : seq_o is the final term of a counted run
//   ovf_o                : sticky overflow for the current run
//   busy_o               : a run is active
//   err_o                : one-cycle pulse after a start with an illegal order
module seq_gen_kbonacci
   import seq_gen_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int MAX_ORDER = 4,
   parameter int CNT_W     = 16,
   parameter int ORD_W     = $clog2(MAX_ORDER + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_i,
   input  logic [ORD_W-1:0]  order_i,
   input  logic [CNT_W-1:0]  n_terms_i,
   input  logic              sat_en_i,
   output logic [DATA_W-1:0] seq_o,
   output logic [CNT_W-1:0]  idx_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              last_o,
   output logic              ovf_o,
   output logic              busy_o,
   output logic              err_o
);

   state_t state, state_nxt;

   logic [MAX_ORDER-1:0][DATA_W-1:0] win;
   logic [MAX_ORDER-1:1]             tag;     // entry holds an overflowed term
   logic [ORD_W-1:0]                 k;
   logic [CNT_W-1:0]                 n_terms;
   logic                             sat_en;
   logic [CNT_W-1:0]                 idx;
   logic                             last, ovf, err;

   // One spare zero entry above the window so "next entry" is always in range.
   logic [MAX_ORDER:0][DATA_W-1:0]   win_ext;
   logic [MAX_ORDER:1]               tag_ext;
   logic [DATA_W-1:0]                sum;
   logic                             sum_ovf;

   logic order_ok, accept, reject, xfer, done;

   assign order_ok = (order_i >= ORD_W'(ORDER_MIN)) && (order_i <= ORD_W'(MAX_ORDER));
   assign accept   = (state == IDLE) && start_i && order_ok;
   assign reject   = (state == IDLE) && start_i && !order_ok;
   assign xfer     = (state == RUN) && ready_i;
   assign done     = xfer && last;

   assign win_ext = {DATA_W'(0), win};
   assign tag_ext = {1'b0, tag};

   seq_win_sum #(
      .DATA_W    (DATA_W),
      .MAX_ORDER (MAX_ORDER),
      .ORD_W     (ORD_W)
   ) u_sum (
      .win    (win),
      .order  (k),
      .sat_en (sat_en),
      .sum    (sum),
      .ovf    (sum_ovf)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (done)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win     <= '0;
         tag     <= '0;
         k       <= '0;
         n_terms <= '0;
         sat_en  <= 1'b0;
         idx     <= '0;
         last    <= 1'b0;
         ovf     <= 1'b0;
         err     <= 1'b0;
      end else begin
         err <= reject;
         if (accept) begin
            k       <= order_i;
            n_terms <= n_terms_i;
            sat_en  <= sat_en_i;
            idx     <= '0;
            last    <= (n_terms_i == CNT_W'(1));
            ovf     <= 1'b0;
            tag     <= '0;
            // Seed: zeros followed by a single one at position k-1.
            for (int i = 0; i < MAX_ORDER; i++)
               win[i] <= (ORD_W'(i + 1) == order_i) ? DATA_W'(1) : '0;
         end else if (xfer) begin
            idx  <= idx + CNT_W'(1);
            last <= (n_terms != '0) && (idx + CNT_W'(1) == n_terms - CNT_W'(1));
            // The term moving into seq_o is entry 1; flag it as it arrives.
            ovf  <= ovf | tag[1];
            for (int i = 0; i < MAX_ORDER; i++) begin
               if (ORD_W'(i + 1) < k)       win[i] <= win_ext[i + 1];
               else if (ORD_W'(i + 1) == k) win[i] <= sum;
               else                         win[i] <= '0;
            end
            for (int i = 1; i < MAX_ORDER; i++) begin
               if (ORD_W'(i + 1) < k)       tag[i] <= tag_ext[i + 1];
               else if (ORD_W'(i + 1) == k) tag[i] <= sum_ovf;
               else                         tag[i] <= 1'b0;
            end
         end
      end
   end

   assign seq_o   = win[0];
   assign idx_o   = idx;
   assign valid_o = (state == RUN);
   assign busy_o  = (state == RUN);
   assign last_o  = last;
   assign ovf_o   = ovf;
   assign err_o   = err;

endmodule

// File: tb/tb_seq_gen_kbonacci.sv
// Bench for seq_gen_kbonacci at DATA_W=8 so overflow is reachable quickly.
// Expected terms come from a direct arithmetic model of the k-bonacci rule.
module tb_seq_gen_kbonacci;

   localparam int DW = 8;
   localparam int MO = 4;
   localparam int CW = 16;
   localparam int OW = 3;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start_i = 1'b0;
   logic [OW-1:0] order_i = '0;
   logic [CW-1:0] n_terms_i = '0;
   logic          sat_en_i = 1'b0;
   logic          ready_i = 1'b0;
   logic [DW-1:0] seq_o;
   logic [CW-1:0] idx_o;
   logic          valid_o, last_o, ovf_o, busy_o, err_o;

   int tests = 0;
   int fails = 0;
   int exp_v [64];
   bit exp_o [64];

   always #5 clk = ~clk;

   seq_gen_kbonacci #(.DATA_W(DW), .MAX_ORDER(MO), .CNT_W(CW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start_i   (start_i),
      .order_i   (order_i),
      .n_terms_i (n_terms_i),
      .sat_en_i  (sat_en_i),
      .seq_o     (seq_o),
      .idx_o     (idx_o),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .last_o    (last_o),
      .ovf_o     (ovf_o),
      .busy_o    (busy_o),
      .err_o     (err_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // T(n) = 0 for n<k-1, T(k-1)=1, then sum of the previous k stored terms,
   // clamped or wrapped at 2^DW. exp_o[n] = some term 0..n overflowed.
   task automatic build(input int k, input bit sat, input int cnt);
      bit any;
      any = 1'b0;
      for (int n = 0; n < cnt; n++) begin
         bit f;
         int v;
         int s;
         f = 1'b0;
         if (n < k) v = (n == k - 1) ? 1 : 0;
         else begin
            s = 0;
            for (int j = n - k; j < n; j++) s += exp_v[j];
            if (s > 255) begin
               f = 1'b1;
               v = sat ? 255 : s % 256;
            end else v = s;
         end
         any = any | f;
         exp_v[n] = v;
         exp_o[n] = any;
      end
   endtask

   // rmode: 0 = ready held high, 1 = random ready, 2 = random with 5 low cycles.
   // mid: pulse start_i during the run and on the final transfer.
   task automatic run_seq(input int k, input int n, input bit sat, input int rmode, input bit mid);
      int got;
      int cyc;
      bit r;
      got = 0;
      cyc = 0;
      build(k, sat, n);
      start_i = 1'b1;
      order_i = OW'(k);
      n_terms_i = CW'(n);
      sat_en_i = sat;
      ready_i = 1'b0;
      tick();
      start_i = 1'b0;
      check("busy_rise", busy_o, 1);
      while (got < n && cyc < 400) begin
         check("valid", valid_o, 1);
         check("seq", seq_o, exp_v[got]);
         check("idx", idx_o, got);
         check("last", last_o, (got == n - 1) ? 1 : 0);
         check("ovf", ovf_o, exp_o[got]);
         case (rmode)
            0:       r = 1'b1;
            1:       r = 1'($urandom_range(0, 1));
            default: r = (cyc >= 3 && cyc < 8) ? 1'b0 : 1'($urandom_range(0, 1));
         endcase
         if (mid && (cyc == 4 || (r && got == n - 1))) begin
            start_i = 1'b1;
            order_i = 3'd3;
            n_terms_i = CW'(2);
            sat_en_i = ~sat;
         end else start_i = 1'b0;
         ready_i = r;
         tick();
         if (r) got++;
         cyc++;
      end
      start_i = 1'b0;
      ready_i = 1'b0;
      check("run_complete", got, n);
      check("busy_fall", busy_o, 0);
      check("valid_fall", valid_o, 0);
      check("err_quiet", err_o, 0);
   endtask

   task automatic bad_start(input int o);
      start_i = 1'b1;
      order_i = OW'(o);
      n_terms_i = CW'(5);
      tick();
      start_i = 1'b0;
      check("err_pulse", err_o, 1);
      check("err_busy", busy_o, 0);
      check("err_valid", valid_o, 0);
      tick();
      check("err_clear", err_o, 0);
      check("err_busy2", busy_o, 0);
      check("err_valid2", valid_o, 0);
   endtask

   initial begin
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_seq", seq_o, 0);
      check("rst_idx", idx_o, 0);
      check("rst_valid", valid_o, 0);
      check("rst_last", last_o, 0);
      check("rst_ovf", ovf_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_err", err_o, 0);
      reset_n = 1'b1;
      tick();

      // Fibonacci, Tribonacci, Tetranacci
      run_seq(2, 10, 1'b0, 0, 1'b0);
      run_seq(3, 8, 1'b0, 0, 1'b0);
      run_seq(4, 10, 1'b0, 0, 1'b0);

      // Backpressure with a forced 5-cycle stall
      run_seq(2, 10, 1'b0, 2, 1'b0);

      // Overflow: wrap, then saturate, then a clean run clears ovf_o
      run_seq(2, 16, 1'b0, 0, 1'b0);
      run_seq(2, 16, 1'b1, 0, 1'b0);
      run_seq(2, 3, 1'b0, 0, 1'b0);

      // Illegal orders
      bad_start(1);
      bad_start(MO + 1);
      bad_start(0);

      // start_i pulses while busy are ignored
      run_seq(2, 10, 1'b0, 1, 1'b1);

      // Asynchronous reset in the middle of a free run
      build(3, 1'b0, 8);
      start_i = 1'b1;
      order_i = 3'd3;
      n_terms_i = '0;
      sat_en_i = 1'b0;
      tick();
      start_i = 1'b0;
      ready_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         check("fr_seq", seq_o, exp_v[c]);
         check("fr_idx", idx_o, c);
         check("fr_last", last_o, 0);
         tick();
      end
      check("fr_idx5", idx_o, 5);
      reset_n = 1'b0;
      #1;
      check("mrst_seq", seq_o, 0);
      check("mrst_idx", idx_o, 0);
      check("mrst_valid", valid_o, 0);
      check("mrst_busy", busy_o, 0);
      check("mrst_last", last_o, 0);
      check("mrst_ovf", ovf_o, 0);
      ready_i = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      run_seq(3, 6, 1'b0, 0, 1'b0);

      // Random runs
      for (int i = 0; i < 6; i++)
         run_seq(int'($urandom_range(2, MO)), int'($urandom_range(1, 24)),
                 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
